// File: rtl/peak_trap_ctrl_if.sv
// CSR-unit access port shared between the pipeline and the trap sequencer.
// The sequencer is the master; the CSR unit is the slave and returns registered read data.
interface peak_trap_ctrl_if;
  logic [11:0] CSR_ADDR;
  logic        CSR_WE;
  logic [31:0] CSR_WDATA;
  logic [31:0] CSR_WMASK;
  logic [31:0] CSR_RDATA;
  logic        CSR_EXCEPTION;
  logic [11:0] CSR_EXC_CODE;
  logic [31:0] CSR_EXC_ADDR;
  logic [31:0] CSR_EXC_PC;

  modport master (
    output CSR_ADDR, CSR_WE, CSR_WDATA, CSR_WMASK,
    output CSR_EXCEPTION, CSR_EXC_CODE, CSR_EXC_ADDR, CSR_EXC_PC,
    input  CSR_RDATA
  );

  modport slave (
    input  CSR_ADDR, CSR_WE, CSR_WDATA, CSR_WMASK,
    input  CSR_EXCEPTION, CSR_EXC_CODE, CSR_EXC_ADDR, CSR_EXC_PC,
    output CSR_RDATA
  );
endinterface

// File: rtl/peak_trap_ctrl.sv
// Trap sequencer for the PEAK machine-mode CSR unit: drains the pipeline, updates
// mepc/mstatus over the shared CSR port, then issues a PC redirect and flush.
module peak_trap_ctrl #(
  parameter int unsigned DRAIN_MAX = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EXC_REQ,
  input  logic [11:0]      EXC_CODE,
  input  logic [31:0]      EXC_ADDR,
  input  logic [31:0]      EXC_PC,
  input  logic             MRET_REQ,
  input  logic [31:0]      NEXT_PC,
  input  logic             INTERRUPT,
  input  logic             PIPE_IDLE,
  input  logic [31:0]      HANDLER_PC,
  input  logic [31:0]      EPC,
  input  logic [11:0]      P_CSR_ADDR,
  input  logic             P_CSR_WE,
  input  logic [31:0]      P_CSR_WDATA,
  input  logic [31:0]      P_CSR_WMASK,
  peak_trap_ctrl_if.master csr,
  output logic             STALL,
  output logic             FLUSH,
  output logic             REDIRECT_VALID,
  output logic [31:0]      REDIRECT_PC,
  output logic             DRAIN_TO
);

  typedef enum logic [2:0] {IDLE, DRAIN, RD_ST, WR_ST, REDIR} state_e;
  typedef enum logic [1:0] {KIND_EXC, KIND_INT, KIND_MRET} kind_e;

  localparam logic [7:0]  DRAIN_LAST   = 8'(DRAIN_MAX - 1);
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [31:0] MSTATUS_MASK = 32'h0000_1888;

  state_e      state_q, state_d;
  kind_e       kind_q, kind_d;
  logic [11:0] code_q, code_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] next_pc_q, next_pc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        drain_to_q, drain_to_d;

  logic        req_any;
  logic        drain_exit;
  logic [31:0] mstatus_wdata;
  logic        rdata_unused;

  assign req_any    = EXC_REQ | MRET_REQ | INTERRUPT;
  assign drain_exit = PIPE_IDLE || (cnt_q == DRAIN_LAST);

  assign csr.CSR_EXC_CODE = code_q;
  assign csr.CSR_EXC_ADDR = addr_q;
  assign csr.CSR_EXC_PC   = pc_q;
  assign DRAIN_TO         = drain_to_q;
  assign rdata_unused     = ^{csr.CSR_RDATA[31:8], csr.CSR_RDATA[6:4], csr.CSR_RDATA[2:0]};

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      kind_q     <= KIND_EXC;
      code_q     <= '0;
      addr_q     <= '0;
      pc_q       <= '0;
      next_pc_q  <= '0;
      cnt_q      <= '0;
      drain_to_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      code_q     <= code_d;
      addr_q     <= addr_d;
      pc_q       <= pc_d;
      next_pc_q  <= next_pc_d;
      cnt_q      <= cnt_d;
      drain_to_q <= drain_to_d;
    end
  end

  // Trap entry stacks MIE into MPIE and enters M-mode; MRET restores MIE from MPIE.
  always_comb begin
    mstatus_wdata = '0;
    if (kind_q == KIND_MRET) begin
      mstatus_wdata[7] = 1'b1;
      mstatus_wdata[3] = csr.CSR_RDATA[7];
    end else begin
      mstatus_wdata[12:11] = 2'b11;
      mstatus_wdata[7]     = csr.CSR_RDATA[3];
    end
  end

  always_comb begin
    state_d           = state_q;
    kind_d            = kind_q;
    code_d            = code_q;
    addr_d            = addr_q;
    pc_d              = pc_q;
    next_pc_d         = next_pc_q;
    cnt_d             = cnt_q;
    drain_to_d        = drain_to_q;
    STALL             = 1'b1;
    FLUSH             = 1'b0;
    REDIRECT_VALID    = 1'b0;
    REDIRECT_PC       = '0;
    csr.CSR_ADDR      = CSR_MSTATUS;
    csr.CSR_WE        = 1'b0;
    csr.CSR_WDATA     = '0;
    csr.CSR_WMASK     = '0;
    csr.CSR_EXCEPTION = 1'b0;

    unique case (state_q)
      IDLE: begin
        STALL         = req_any;
        csr.CSR_ADDR  = P_CSR_ADDR;
        csr.CSR_WE    = P_CSR_WE;
        csr.CSR_WDATA = P_CSR_WDATA;
        csr.CSR_WMASK = P_CSR_WMASK;
        if (req_any) begin
          kind_d    = EXC_REQ ? KIND_EXC : (MRET_REQ ? KIND_MRET : KIND_INT);
          code_d    = EXC_CODE;
          addr_d    = EXC_ADDR;
          pc_d      = EXC_PC;
          next_pc_d = NEXT_PC;
          cnt_d     = '0;
          state_d   = DRAIN;
        end
      end
      DRAIN: begin
        cnt_d = cnt_q + 8'd1;
        if (drain_exit) begin
          drain_to_d = drain_to_q | ~PIPE_IDLE;
          state_d    = RD_ST;
          case (kind_q)
            KIND_EXC: csr.CSR_EXCEPTION = 1'b1;
            KIND_INT: begin
              csr.CSR_WE    = 1'b1;
              csr.CSR_ADDR  = CSR_MEPC;
              csr.CSR_WDATA = next_pc_q;
              csr.CSR_WMASK = 32'hFFFF_FFFF;
            end
            default: ;
          endcase
        end
      end
      RD_ST: state_d = WR_ST;
      WR_ST: begin
        csr.CSR_WE    = 1'b1;
        csr.CSR_WDATA = mstatus_wdata;
        csr.CSR_WMASK = MSTATUS_MASK;
        state_d       = REDIR;
      end
      REDIR: begin
        REDIRECT_VALID = 1'b1;
        FLUSH          = 1'b1;
        REDIRECT_PC    = ((kind_q == KIND_MRET) ? EPC : HANDLER_PC) & ~32'h3;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_peak_trap_ctrl.sv
// Directed bench for peak_trap_ctrl: a table of complete trap sequences against a small
// CSR-unit model, plus hand sequences for drain wait/timeout and mid-sequence reset.
module tb_peak_trap_ctrl;
  logic        CLK = 1'b0;
  logic        RST_N;
  logic        EXC_REQ, MRET_REQ, INTERRUPT, PIPE_IDLE;
  logic [11:0] EXC_CODE;
  logic [31:0] EXC_ADDR, EXC_PC, NEXT_PC, HANDLER_PC, EPC;
  logic [11:0] P_CSR_ADDR;
  logic        P_CSR_WE;
  logic [31:0] P_CSR_WDATA, P_CSR_WMASK;
  logic        STALL, FLUSH, REDIRECT_VALID, DRAIN_TO;
  logic [31:0] REDIRECT_PC;

  peak_trap_ctrl_if csr_bus();

  peak_trap_ctrl #(.DRAIN_MAX(16)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .EXC_REQ(EXC_REQ), .EXC_CODE(EXC_CODE), .EXC_ADDR(EXC_ADDR), .EXC_PC(EXC_PC),
    .MRET_REQ(MRET_REQ), .NEXT_PC(NEXT_PC), .INTERRUPT(INTERRUPT), .PIPE_IDLE(PIPE_IDLE),
    .HANDLER_PC(HANDLER_PC), .EPC(EPC),
    .P_CSR_ADDR(P_CSR_ADDR), .P_CSR_WE(P_CSR_WE), .P_CSR_WDATA(P_CSR_WDATA),
    .P_CSR_WMASK(P_CSR_WMASK),
    .csr(csr_bus),
    .STALL(STALL), .FLUSH(FLUSH), .REDIRECT_VALID(REDIRECT_VALID),
    .REDIRECT_PC(REDIRECT_PC), .DRAIN_TO(DRAIN_TO)
  );

  always #5 CLK = ~CLK;

  // CSR unit model: masked writes, EXCEPTION loads mepc, registered read data.
  logic [31:0] m_mstatus, m_mepc, m_mtvec;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [31:0] mask);
    return (old & ~mask) | (data & mask);
  endfunction

  always @(posedge CLK) begin
    if (csr_bus.CSR_EXCEPTION) m_mepc <= csr_bus.CSR_EXC_PC;
    if (csr_bus.CSR_WE) begin
      case (csr_bus.CSR_ADDR)
        12'h300: m_mstatus <= merge(m_mstatus, csr_bus.CSR_WDATA, csr_bus.CSR_WMASK);
        12'h341: m_mepc    <= merge(m_mepc, csr_bus.CSR_WDATA, csr_bus.CSR_WMASK);
        12'h305: m_mtvec   <= merge(m_mtvec, csr_bus.CSR_WDATA, csr_bus.CSR_WMASK);
        default: ;
      endcase
    end
    case (csr_bus.CSR_ADDR)
      12'h300: csr_bus.CSR_RDATA <= m_mstatus;
      12'h341: csr_bus.CSR_RDATA <= m_mepc;
      12'h305: csr_bus.CSR_RDATA <= m_mtvec;
      default: csr_bus.CSR_RDATA <= 32'h0;
    endcase
  end

  assign HANDLER_PC = m_mtvec;
  assign EPC        = m_mepc;

  int redirects = 0;
  always @(negedge CLK) if (REDIRECT_VALID === 1'b1) redirects++;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        exc, mret, intr;
    logic [11:0] code;
    logic [31:0] pc, eaddr, next_pc;
    logic [31:0] mstatus0, mepc0, mtvec0;
    logic        c1_exc, c1_we;
    logic [11:0] c1_addr;
    logic [31:0] c1_wdata, c3_wdata, redir_pc, mepc_after;
  } vec_t;

  vec_t vecs[7];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic exc, input logic mret, input logic intr,
                               input logic [11:0] code, input logic [31:0] pc,
                               input logic [31:0] eaddr, input logic [31:0] npc);
    EXC_REQ   = exc;
    MRET_REQ  = mret;
    INTERRUPT = intr;
    EXC_CODE  = code;
    EXC_PC    = pc;
    EXC_ADDR  = eaddr;
    NEXT_PC   = npc;
  endtask

  task automatic csrWrite(input logic [11:0] addr, input logic [31:0] data);
    P_CSR_ADDR  = addr;
    P_CSR_WE    = 1'b1;
    P_CSR_WDATA = data;
    P_CSR_WMASK = 32'hFFFF_FFFF;
    tick();
    P_CSR_WE = 1'b0;
  endtask

  task automatic csrRead(input logic [11:0] addr, output logic [31:0] data);
    P_CSR_ADDR = addr;
    P_CSR_WE   = 1'b0;
    tick();
    data = csr_bus.CSR_RDATA;
  endtask

  task automatic runVector(input int i);
    vec_t        v;
    int          r0;
    logic [31:0] rd;
    v = vecs[i];
    csrWrite(12'h300, v.mstatus0);
    csrWrite(12'h341, v.mepc0);
    csrWrite(12'h305, v.mtvec0);
    PIPE_IDLE = 1'b1;
    r0 = redirects;
    applyStimulus(v.exc, v.mret, v.intr, v.code, v.pc, v.eaddr, v.next_pc);
    #3;
    checkOutput($sformatf("v%0d_c0_stall", i), 32'(STALL), 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 32'h0, 32'h0);
    P_CSR_ADDR  = 12'h305;
    P_CSR_WE    = 1'b1;
    P_CSR_WDATA = 32'hBAD0_0BAD;
    #3;
    checkOutput($sformatf("v%0d_c1_exc", i), 32'(csr_bus.CSR_EXCEPTION), 32'(v.c1_exc));
    checkOutput($sformatf("v%0d_c1_we", i), 32'(csr_bus.CSR_WE), 32'(v.c1_we));
    checkOutput($sformatf("v%0d_c1_addr", i), 32'(csr_bus.CSR_ADDR), 32'(v.c1_addr));
    if (v.c1_we) begin
      checkOutput($sformatf("v%0d_c1_wdata", i), csr_bus.CSR_WDATA, v.c1_wdata);
      checkOutput($sformatf("v%0d_c1_wmask", i), csr_bus.CSR_WMASK, 32'hFFFF_FFFF);
    end
    tick();
    #3;
    checkOutput($sformatf("v%0d_c2_addr", i), 32'(csr_bus.CSR_ADDR), 32'h300);
    checkOutput($sformatf("v%0d_c2_we", i), 32'(csr_bus.CSR_WE), 32'd0);
    checkOutput($sformatf("v%0d_c2_stall", i), 32'(STALL), 32'd1);
    if (v.exc) begin
      checkOutput($sformatf("v%0d_exc_code", i), 32'(csr_bus.CSR_EXC_CODE), 32'(v.code));
      checkOutput($sformatf("v%0d_exc_pc", i), csr_bus.CSR_EXC_PC, v.pc);
      checkOutput($sformatf("v%0d_exc_addr", i), csr_bus.CSR_EXC_ADDR, v.eaddr);
    end
    tick();
    #3;
    checkOutput($sformatf("v%0d_c3_we", i), 32'(csr_bus.CSR_WE), 32'd1);
    checkOutput($sformatf("v%0d_c3_addr", i), 32'(csr_bus.CSR_ADDR), 32'h300);
    checkOutput($sformatf("v%0d_c3_wmask", i), csr_bus.CSR_WMASK, 32'h0000_1888);
    checkOutput($sformatf("v%0d_c3_wdata", i), csr_bus.CSR_WDATA, v.c3_wdata);
    tick();
    #3;
    checkOutput($sformatf("v%0d_c4_redir", i), 32'(REDIRECT_VALID), 32'd1);
    checkOutput($sformatf("v%0d_c4_flush", i), 32'(FLUSH), 32'd1);
    checkOutput($sformatf("v%0d_c4_pc", i), REDIRECT_PC, v.redir_pc);
    checkOutput($sformatf("v%0d_c4_we", i), 32'(csr_bus.CSR_WE), 32'd0);
    tick();
    P_CSR_WE = 1'b0;
    #3;
    checkOutput($sformatf("v%0d_c5_stall", i), 32'(STALL), 32'd0);
    checkOutput($sformatf("v%0d_c5_redir", i), 32'(REDIRECT_VALID), 32'd0);
    checkOutput($sformatf("v%0d_pulses", i), 32'(redirects - r0), 32'd1);
    csrRead(12'h341, rd);
    checkOutput($sformatf("v%0d_mepc", i), rd, v.mepc_after);
    csrRead(12'h300, rd);
    checkOutput($sformatf("v%0d_mstatus", i), rd, (v.mstatus0 & ~32'h0000_1888) | v.c3_wdata);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          first;
    int          r0;
    logic [31:0] rd;

    //            exc   mret  intr  code     pc            eaddr         next_pc       mstatus0      mepc0         mtvec0        c1exc c1we  c1addr   c1wdata       c3wdata       redir         mepc_after
    vecs[0] = '{1'b1, 1'b0, 1'b0, 12'h002, 32'h0000_0100, 32'h0000_DEAD, 32'h0000_0104, 32'h0000_0008, 32'h0000_0000, 32'h0000_0080, 1'b1, 1'b0, 12'h300, 32'h0000_0000, 32'h0000_1880, 32'h0000_0080, 32'h0000_0100};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 12'h000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0204, 32'h0000_0008, 32'h0000_0000, 32'h0000_0080, 1'b0, 1'b1, 12'h341, 32'h0000_0204, 32'h0000_1880, 32'h0000_0080, 32'h0000_0204};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 12'h000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0080, 32'h0000_0204, 32'h0000_0080, 1'b0, 1'b0, 12'h300, 32'h0000_0000, 32'h0000_0088, 32'h0000_0204, 32'h0000_0204};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 12'h00B, 32'h0000_0400, 32'h0000_0044, 32'h0000_0999, 32'h0000_0000, 32'h0000_0000, 32'h0000_0080, 1'b1, 1'b0, 12'h300, 32'h0000_0000, 32'h0000_1800, 32'h0000_0080, 32'h0000_0400};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 12'h005, 32'h1234_5678, 32'hCAFE_0000, 32'h0000_0000, 32'hFFFF_FFF7, 32'h0000_0000, 32'h8000_0103, 1'b1, 1'b0, 12'h300, 32'h0000_0000, 32'h0000_1800, 32'h8000_0100, 32'h1234_5678};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 12'h000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0777, 32'h0000_1808, 32'h0000_0A00, 32'h0000_0080, 1'b0, 1'b0, 12'h300, 32'h0000_0000, 32'h0000_0080, 32'h0000_0A00, 32'h0000_0A00};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 12'h000, 32'h0000_0000, 32'h0000_0000, 32'h0000_1000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0080, 1'b0, 1'b1, 12'h341, 32'h0000_1000, 32'h0000_1800, 32'h0000_0080, 32'h0000_1000};

    RST_N = 1'b0;
    PIPE_IDLE = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 32'h0, 32'h0);
    P_CSR_ADDR = 12'h0; P_CSR_WE = 1'b0; P_CSR_WDATA = 32'h0; P_CSR_WMASK = 32'h0;
    repeat (3) tick();
    #3;
    checkOutput("rst_stall", 32'(STALL), 32'd0);
    checkOutput("rst_redir", 32'(REDIRECT_VALID), 32'd0);
    checkOutput("rst_flush", 32'(FLUSH), 32'd0);
    checkOutput("rst_exception", 32'(csr_bus.CSR_EXCEPTION), 32'd0);
    checkOutput("rst_drain_to", 32'(DRAIN_TO), 32'd0);
    checkOutput("rst_exc_code", 32'(csr_bus.CSR_EXC_CODE), 32'd0);
    checkOutput("rst_exc_pc", csr_bus.CSR_EXC_PC, 32'd0);
    RST_N = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) runVector(i);

    // Pipeline stays busy for three DRAIN cycles, then drains in the fourth.
    csrWrite(12'h300, 32'h0000_0008);
    csrWrite(12'h305, 32'h0000_0080);
    PIPE_IDLE = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 12'h004, 32'h0000_0300, 32'h0, 32'h0);
    #3;
    checkOutput("wait_c0_stall", 32'(STALL), 32'd1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 32'h0, 32'h0);
      #3;
      checkOutput($sformatf("wait_c%0d_exc", k), 32'(csr_bus.CSR_EXCEPTION), 32'd0);
    end
    tick();
    PIPE_IDLE = 1'b1;
    #3;
    checkOutput("wait_exit_exc", 32'(csr_bus.CSR_EXCEPTION), 32'd1);
    tick();
    #3;
    checkOutput("wait_drain_to", 32'(DRAIN_TO), 32'd0);
    tick();
    tick();
    #3;
    checkOutput("wait_redir", 32'(REDIRECT_VALID), 32'd1);
    checkOutput("wait_redir_pc", REDIRECT_PC, 32'h0000_0080);
    tick();

    // Pipeline never drains: forced exit after DRAIN_MAX cycles.
    PIPE_IDLE = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 12'h006, 32'h0000_0500, 32'h0, 32'h0);
    first = 0;
    for (int k = 1; k <= 24 && first == 0; k++) begin
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 32'h0, 32'h0);
      #3;
      if (csr_bus.CSR_EXCEPTION === 1'b1) first = k;
    end
    checkOutput("to_exit_cycle", 32'(first), 32'd16);
    tick();
    #3;
    checkOutput("to_drain_to", 32'(DRAIN_TO), 32'd1);
    tick();
    tick();
    #3;
    checkOutput("to_redir", 32'(REDIRECT_VALID), 32'd1);
    checkOutput("to_redir_pc", REDIRECT_PC, 32'h0000_0080);
    tick();
    PIPE_IDLE = 1'b1;
    #3;
    checkOutput("to_stall_after", 32'(STALL), 32'd0);
    checkOutput("to_sticky", 32'(DRAIN_TO), 32'd1);

    // Reset while the mstatus write is on the port: no redirect afterwards.
    csrWrite(12'h300, 32'h0000_0008);
    r0 = redirects;
    applyStimulus(1'b1, 1'b0, 1'b0, 12'h007, 32'h0000_0600, 32'h0000_0011, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 32'h0, 32'h0);
    tick();
    tick();
    RST_N = 1'b0;
    #3;
    checkOutput("rstmid_wr_we", 32'(csr_bus.CSR_WE), 32'd1);
    tick();
    #3;
    checkOutput("rstmid_stall", 32'(STALL), 32'd0);
    checkOutput("rstmid_redir", 32'(REDIRECT_VALID), 32'd0);
    checkOutput("rstmid_flush", 32'(FLUSH), 32'd0);
    checkOutput("rstmid_drain_to", 32'(DRAIN_TO), 32'd0);
    checkOutput("rstmid_exc_code", 32'(csr_bus.CSR_EXC_CODE), 32'd0);
    P_CSR_ADDR  = 12'h7C0;
    P_CSR_WE    = 1'b1;
    P_CSR_WDATA = 32'h1234_5678;
    P_CSR_WMASK = 32'h00FF_00FF;
    #1;
    checkOutput("pass_addr", 32'(csr_bus.CSR_ADDR), 32'h7C0);
    checkOutput("pass_we", 32'(csr_bus.CSR_WE), 32'd1);
    checkOutput("pass_wdata", csr_bus.CSR_WDATA, 32'h1234_5678);
    checkOutput("pass_wmask", csr_bus.CSR_WMASK, 32'h00FF_00FF);
    P_CSR_WE = 1'b0;
    tick();
    RST_N = 1'b1;
    repeat (4) tick();
    #3;
    checkOutput("rstmid_no_redirect", 32'(redirects - r0), 32'd0);
    checkOutput("rstmid_idle_stall", 32'(STALL), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/peak_trap_ctrl.md
Name: peak_trap_ctrl

Overview:
Trap sequencer for the PEAK core's machine-mode CSR unit.
- Accepts exception, MRET and interrupt events from the commit stage and stalls the pipeline until it drains.
- Drives the CSR unit's EXCEPTION and write port to update mepc and mstatus, then issues a PC redirect and flush.
- Owns the CSR access port while a trap is in flight: it muxes the pipeline's CSR instruction port and blocks it during the sequence.

Parameters:
DRAIN_MAX, 16, maximum DRAIN cycles before forced progress (range 1..255)

Ports:
CLK  in  1  clock
RST_N  in  1  synchronous active-low reset
EXC_REQ  in  1  commit-stage exception (ECALL included), level, sampled in IDLE
EXC_CODE  in  12  exception cause code
EXC_ADDR  in  32  faulting data address
EXC_PC  in  32  PC of faulting instruction
MRET_REQ  in  1  commit-stage MRET
NEXT_PC  in  32  PC of next instruction to execute (interrupt return address)
INTERRUPT  in  1  pending enabled interrupt from CSR unit
PIPE_IDLE  in  1  pipeline drained, no instruction in flight
HANDLER_PC  in  32  mtvec from CSR unit
EPC  in  32  mepc from CSR unit
P_CSR_ADDR  in  12  pipeline CSR address
P_CSR_WE  in  1  pipeline CSR write enable
P_CSR_WDATA  in  32  pipeline CSR write data
P_CSR_WMASK  in  32  pipeline CSR write mask
CSR_ADDR  out  12  to CSR unit
CSR_WE  out  1  to CSR unit
CSR_WDATA  out  32  to CSR unit
CSR_WMASK  out  32  to CSR unit
CSR_RDATA  in  32  from CSR unit; registered, valid one cycle after CSR_ADDR
CSR_EXCEPTION  out  1  one-cycle pulse to CSR EXCEPTION
CSR_EXC_CODE  out  12  captured EXC_CODE
CSR_EXC_ADDR  out  32  captured EXC_ADDR
CSR_EXC_PC  out  32  captured EXC_PC
STALL  out  1  freeze fetch/issue
FLUSH  out  1  one-cycle pipeline flush
REDIRECT_VALID  out  1  one-cycle PC redirect strobe
REDIRECT_PC  out  32  redirect target, bits[1:0]=0
DRAIN_TO  out  1  sticky: a drain timed out

Behaviour:
- States: IDLE, DRAIN, RD_ST, WR_ST, REDIR.
- Reset: state IDLE, all strobes 0, DRAIN_TO 0, captured registers 0, drain counter 0. Reset mid-sequence abandons it; no replay.
- IDLE request priority: EXC_REQ > MRET_REQ > INTERRUPT. Lower-priority events in the same cycle are dropped; the flush forces the pipeline to reissue them.
- IDLE on a request: capture kind, EXC_CODE/ADDR/PC and NEXT_PC, then go to DRAIN.
- STALL is combinationally 1 in the accepting IDLE cycle and 1 in every non-IDLE state.
- DRAIN:
  - Counter increments each cycle.
  - Leave when PIPE_IDLE=1 or counter reaches DRAIN_MAX-1; the timeout exit sets DRAIN_TO.
  - Exit-cycle action for an exception: CSR_EXCEPTION=1.
  - Exit-cycle action for an interrupt: CSR_WE=1, ADDR=341h, WDATA=captured NEXT_PC, WMASK=FFFFFFFFh.
  - Exit-cycle action for MRET: none.
  - Next state: RD_ST.
- RD_ST: CSR_ADDR=300h, CSR_WE=0; next WR_ST.
- WR_ST: CSR_ADDR=300h, CSR_WE=1, WMASK=00001888h; next REDIR.
  - Trap (exception or interrupt) write: MPP=11, MPIE=CSR_RDATA[3], MIE=0.
  - MRET write: MPP=00, MPIE=1, MIE=CSR_RDATA[7].
- REDIR: REDIRECT_VALID=1, FLUSH=1; next IDLE.
  - Trap: REDIRECT_PC = HANDLER_PC & ~3.
  - MRET: REDIRECT_PC = EPC.
- Minimum latency: request cycle c0, redirect in c4.
- CSR port mux:
  - In IDLE, P_CSR_* pass through unchanged, combinationally.
  - Otherwise the controller drives the port: CSR_ADDR=300h except as specified above, and the pipeline's WE is forced to 0.
- Requests arriving in non-IDLE states are ignored.
- CSR_EXC_* hold their captured values until the next capture.

Test Plan:
1. PIPE_IDLE=1; EXC_REQ with code 2, EXC_PC=100h; HANDLER_PC=80h; mstatus MIE=1 -> CSR_EXCEPTION in c1; mstatus write WDATA=00001880h in c3; REDIRECT_PC=80h in c4; STALL high c0-c4.
2. INTERRUPT with NEXT_PC=204h, MIE=1 -> c1 write to 341h with WDATA=204h; MIE cleared; redirect to mtvec; mepc reads 204h afterwards.
3. MRET with mstatus MPIE=1, MIE=0, EPC=204h -> c3 WDATA=00000088h; redirect 204h; then INTERRUPT re-enters.
4. EXC_REQ, MRET_REQ and INTERRUPT in the same cycle -> exception sequence only; exactly one REDIRECT_VALID pulse.
5. PIPE_IDLE held 0 with DRAIN_MAX=16 -> DRAIN lasts 16 cycles; DRAIN_TO=1; sequence still completes.
6. RST_N low during WR_ST -> next cycle IDLE; STALL=0; P_CSR_* pass through; no redirect issued.
